// File: rtl/sau_serdes.sv
// Parametrised full-duplex serial/parallel adapter with valid/ready handshakes on both
// parallel sides, a shared bit-rate strobe and an internal loopback path.
module sau_serdes #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             loopback,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             sout,
    output logic             sout_sof,
    output logic             sout_act,
    input  logic             sin,
    input  logic             sin_sof,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_ovf,
    output logic             rx_ferr
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } tx_state_t;

    tx_state_t        state, state_n;
    logic [WIDTH-1:0] tx_sr, tx_sr_n;
    logic [CW-1:0]    tx_cnt, tx_cnt_n;
    logic             tx_bit;
    logic             tx_last;
    logic             tx_hs;

    // The outgoing bit always sits at the end of the shift register facing the line.
    assign tx_bit   = (LSB_FIRST != 0) ? tx_sr[0] : tx_sr[WIDTH-1];
    assign tx_last  = (state == SHIFT) && bit_en && (tx_cnt == LAST);
    assign tx_ready = (state == IDLE) || tx_last;
    assign tx_hs    = tx_valid && tx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            tx_sr  <= '0;
            tx_cnt <= '0;
        end else begin
            state  <= state_n;
            tx_sr  <= tx_sr_n;
            tx_cnt <= tx_cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        tx_sr_n  = tx_sr;
        tx_cnt_n = tx_cnt;
        sout     = 1'b1;
        sout_sof = 1'b0;
        sout_act = 1'b0;

        if (state == SHIFT) begin
            sout     = tx_bit;
            sout_act = 1'b1;
            sout_sof = (tx_cnt == '0);
        end

        // A handshake on the last bit reloads directly, so words run back-to-back.
        if (tx_hs) begin
            state_n  = SHIFT;
            tx_sr_n  = tx_data;
            tx_cnt_n = '0;
        end else if ((state == SHIFT) && bit_en) begin
            if (tx_last) begin
                state_n = IDLE;
            end else begin
                tx_cnt_n = tx_cnt + 1'b1;
                tx_sr_n  = (LSB_FIRST != 0) ? (tx_sr >> 1) : (tx_sr << 1);
            end
        end
    end

    logic             rx_bit;
    logic             rx_sof;
    logic [CW-1:0]    rx_cnt, rx_cnt_n;
    logic [CW-1:0]    rx_pos;
    logic [CW-1:0]    rx_idx;
    logic [WIDTH-1:0] rx_sr, rx_word;
    logic             rx_done;
    logic             ferr_set;
    logic             ovf_set;

    assign rx_bit = loopback ? sout : sin;
    assign rx_sof = loopback ? sout_sof : sin_sof;
    assign rx_pos = rx_sof ? '0 : rx_cnt;
    assign rx_idx = (LSB_FIRST != 0) ? rx_pos : (LAST - rx_pos);

    // A start-of-word marker always realigns the receiver, discarding any partial word.
    always_comb begin
        rx_cnt_n = rx_cnt;
        rx_word  = rx_sr;
        rx_done  = 1'b0;
        ferr_set = 1'b0;
        if (bit_en) begin
            if (rx_sof) begin
                ferr_set = (rx_cnt != '0);
                rx_word  = '0;
            end
            rx_word[rx_idx] = rx_bit;
            if (rx_pos == LAST) begin
                rx_done  = 1'b1;
                rx_cnt_n = '0;
            end else begin
                rx_cnt_n = rx_pos + 1'b1;
            end
        end
    end

    assign ovf_set = rx_done && rx_valid && !rx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt   <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ovf   <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_cnt <= rx_cnt_n;
            rx_sr  <= rx_word;

            if (rx_done && (!rx_valid || rx_ready)) begin
                rx_data  <= rx_word;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            // Set events take priority over a simultaneous clear.
            if (ovf_set) begin
                rx_ovf <= 1'b1;
            end else if (clr_err) begin
                rx_ovf <= 1'b0;
            end

            if (ferr_set) begin
                rx_ferr <= 1'b1;
            end else if (clr_err) begin
                rx_ferr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sau_serdes.sv
// Self-checking bench for sau_serdes: an 8-bit LSB-first instance in loopback/serial-in
// modes and a 12-bit MSB-first instance for bit-order coverage.
module tb_sau_serdes;

    logic       clk = 1'b0;
    logic       rst;
    logic       bitEn, loopback, clrErr, txValid, sin, sinSof, rxReady;
    logic [7:0] txData;
    logic       txReady, sout, soutSof, soutAct, rxValid, rxOvf, rxFerr;
    logic [7:0] rxData;

    logic        bitEn12, txValid12;
    logic [11:0] txData12;
    logic        txReady12, sout12, soutSof12, soutAct12, rxValid12, rxOvf12, rxFerr12;
    logic [11:0] rxData12;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic [7:0] data;
        logic [7:0] expSeq;
    } vec8_t;

    typedef struct {
        logic [11:0] data;
        logic [11:0] expSeq;
    } vec12_t;

    sau_serdes #(.WIDTH(8), .LSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .bit_en(bitEn), .loopback(loopback), .clr_err(clrErr),
        .tx_data(txData), .tx_valid(txValid), .tx_ready(txReady),
        .sout(sout), .sout_sof(soutSof), .sout_act(soutAct),
        .sin(sin), .sin_sof(sinSof),
        .rx_data(rxData), .rx_valid(rxValid), .rx_ready(rxReady),
        .rx_ovf(rxOvf), .rx_ferr(rxFerr)
    );

    sau_serdes #(.WIDTH(12), .LSB_FIRST(0)) dut12 (
        .clk(clk), .rst(rst), .bit_en(bitEn12), .loopback(1'b1), .clr_err(1'b0),
        .tx_data(txData12), .tx_valid(txValid12), .tx_ready(txReady12),
        .sout(sout12), .sout_sof(soutSof12), .sout_act(soutAct12),
        .sin(1'b0), .sin_sof(1'b0),
        .rx_data(rxData12), .rx_valid(rxValid12), .rx_ready(1'b1),
        .rx_ovf(rxOvf12), .rx_ferr(rxFerr12)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Receive-side scoreboard: every accepted word must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && (rxValid === 1'b1) && rxReady) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rx_unexpected: got %0h expected no word", rxData);
            end else begin
                checkOutput("rx_data_sb", {24'd0, rxData}, {24'd0, sb.pop_front()});
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] d, input bit push);
        int n;
        @(posedge clk); #1;
        txData  = d;
        txValid = 1'b1;
        if (push) sb.push_back(d);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!txReady && n < 50);
        checkOutput("tx_ready_hs", {31'd0, txReady}, 32'd1);
        @(posedge clk); #1;
        txValid = 1'b0;
    endtask

    task automatic pumpBits(input int n);
        bitEn = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
        end
        bitEn = 1'b0;
    endtask

    task automatic driveSin(input logic b, input logic s);
        sin    = b;
        sinSof = s;
        bitEn  = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec8_t  vecs[4];
        vec12_t vecs12[2];
        logic [7:0]  seq, sofs, acts, fw;
        logic [15:0] seq16, sofs16;
        logic [11:0] seq12, sofs12;

        // Expected sequences are written with the first transmitted bit leftmost.
        vecs[0] = '{8'hA5, 8'hA5};
        vecs[1] = '{8'h01, 8'h80};
        vecs[2] = '{8'hE8, 8'h17};
        vecs[3] = '{8'h0F, 8'hF0};
        vecs12[0] = '{12'h801, 12'h801};
        vecs12[1] = '{12'h123, 12'h123};

        rst = 1'b1; bitEn = 0; loopback = 1; clrErr = 0; txValid = 0; txData = 0;
        sin = 1; sinSof = 0; rxReady = 1;
        bitEn12 = 0; txValid12 = 0; txData12 = 0;

        repeat (2) @(negedge clk);
        checkOutput("rst_sout", {31'd0, sout}, 32'd1);
        checkOutput("rst_sof", {31'd0, soutSof}, 32'd0);
        checkOutput("rst_act", {31'd0, soutAct}, 32'd0);
        checkOutput("rst_rx_data", {24'd0, rxData}, 32'd0);
        checkOutput("rst_rx_valid", {31'd0, rxValid}, 32'd0);
        checkOutput("rst_flags", {30'd0, rxOvf, rxFerr}, 32'd0);
        checkOutput("rst_tx_ready", {31'd0, txReady}, 32'd1);
        checkOutput("rst_sout12", {31'd0, sout12}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] single words, loopback, continuous bit_en");
        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].data, 1'b1);
            bitEn = 1'b1;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                seq[7-i]  = sout;
                sofs[7-i] = soutSof;
                acts[7-i] = soutAct;
                @(posedge clk); #1;
            end
            bitEn = 1'b0;
            checkOutput("tx_seq", {24'd0, seq}, {24'd0, vecs[v].expSeq});
            checkOutput("tx_sof", {24'd0, sofs}, 32'h80);
            checkOutput("tx_act", {24'd0, acts}, 32'hFF);
            @(negedge clk);
            checkOutput("idle_sout", {31'd0, sout}, 32'd1);
            checkOutput("idle_act", {31'd0, soutAct}, 32'd0);
            checkOutput("rx_valid_k9", {31'd0, rxValid}, 32'd1);
            @(negedge clk);
            checkOutput("rx_valid_k10", {31'd0, rxValid}, 32'd0);
        end

        $display("[TB] back-to-back words");
        @(posedge clk); #1;
        txData = 8'h3C; txValid = 1'b1; sb.push_back(8'h3C);
        @(posedge clk); #1;
        txData = 8'hC3; sb.push_back(8'hC3); bitEn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            seq16[15-i]  = sout;
            sofs16[15-i] = soutSof;
            if (i == 6) checkOutput("b2b_ready_busy", {31'd0, txReady}, 32'd0);
            if (i == 7) checkOutput("b2b_ready_last", {31'd0, txReady}, 32'd1);
            @(posedge clk); #1;
            if (i == 7) txValid = 1'b0;
        end
        bitEn = 1'b0;
        checkOutput("b2b_seq", {16'd0, seq16}, 32'h3CC3);
        checkOutput("b2b_sof", {16'd0, sofs16}, 32'h8080);
        @(negedge clk);
        checkOutput("b2b_idle", {30'd0, sout, soutAct}, 32'd2);
        checkOutput("b2b_rx_valid", {31'd0, rxValid}, 32'd1);

        $display("[TB] slow bit_en, every third cycle");
        applyStimulus(8'h5A, 1'b1);
        for (int c = 0; c < 22; c++) begin
            bitEn = ((c % 3) == 0);
            @(negedge clk);
            if (c == 2) begin
                checkOutput("slow_hold_bit", {31'd0, sout}, 32'd1);
                checkOutput("slow_hold_sof", {31'd0, soutSof}, 32'd0);
            end
            if (c == 21) checkOutput("slow_not_early", {31'd0, rxValid}, 32'd0);
            @(posedge clk); #1;
        end
        bitEn = 1'b0;
        @(negedge clk);
        checkOutput("slow_rx_valid", {31'd0, rxValid}, 32'd1);

        $display("[TB] overrun");
        @(posedge clk); #1;
        rxReady = 1'b0;
        applyStimulus(8'h11, 1'b1);
        pumpBits(8);
        applyStimulus(8'h22, 1'b0);
        pumpBits(8);
        @(negedge clk);
        checkOutput("ovf_data", {24'd0, rxData}, 32'h11);
        checkOutput("ovf_valid", {31'd0, rxValid}, 32'd1);
        checkOutput("ovf_flag", {31'd0, rxOvf}, 32'd1);
        @(posedge clk); #1;
        clrErr = 1'b1;
        @(posedge clk); #1;
        clrErr = 1'b0;
        @(negedge clk);
        checkOutput("ovf_cleared", {31'd0, rxOvf}, 32'd0);
        @(posedge clk); #1;
        rxReady = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("ovf_drained", {31'd0, rxValid}, 32'd0);

        $display("[TB] framing error on serial input");
        @(posedge clk); #1;
        loopback = 1'b0;
        driveSin(1'b1, 1'b1);
        driveSin(1'b0, 1'b0);
        driveSin(1'b1, 1'b0);
        fw = 8'hF0;
        sb.push_back(fw);
        for (int k = 0; k < 8; k++) driveSin(fw[k], (k == 0));
        bitEn = 1'b0; sinSof = 1'b0; sin = 1'b1;
        @(negedge clk);
        checkOutput("ferr_flag", {31'd0, rxFerr}, 32'd1);
        checkOutput("ferr_data", {24'd0, rxData}, 32'hF0);
        @(posedge clk); #1;
        clrErr = 1'b1;
        @(posedge clk); #1;
        clrErr = 1'b0;
        @(negedge clk);
        checkOutput("ferr_cleared", {31'd0, rxFerr}, 32'd0);

        $display("[TB] 12-bit MSB-first instance");
        for (int v = 0; v < 2; v++) begin
            @(posedge clk); #1;
            txData12 = vecs12[v].data; txValid12 = 1'b1;
            @(negedge clk);
            checkOutput("tx12_ready", {31'd0, txReady12}, 32'd1);
            @(posedge clk); #1;
            txValid12 = 1'b0; bitEn12 = 1'b1;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                seq12[11-i]  = sout12;
                sofs12[11-i] = soutSof12;
                @(posedge clk); #1;
            end
            bitEn12 = 1'b0;
            checkOutput("tx12_seq", {20'd0, seq12}, {20'd0, vecs12[v].expSeq});
            checkOutput("tx12_sof", {20'd0, sofs12}, 32'h800);
            @(negedge clk);
            checkOutput("rx12_valid", {31'd0, rxValid12}, 32'd1);
            checkOutput("rx12_data", {20'd0, rxData12}, {20'd0, vecs12[v].data});
        end

        $display("[TB] reset mid-word");
        @(posedge clk); #1;
        loopback = 1'b1;
        applyStimulus(8'hA5, 1'b0);
        pumpBits(4);
        rst = 1'b1;
        #1;
        checkOutput("rstmid_tx", {29'd0, sout, soutSof, soutAct}, 32'd4);
        checkOutput("rstmid_rx_valid", {31'd0, rxValid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rstmid_quiet", {29'd0, rxValid, rxOvf, rxFerr}, 32'd0);
        applyStimulus(8'h96, 1'b1);
        pumpBits(8);
        @(negedge clk);
        checkOutput("rstmid_next_valid", {31'd0, rxValid}, 32'd1);
        checkOutput("rstmid_next_ferr", {31'd0, rxFerr}, 32'd0);

        repeat (3) @(negedge clk);
        checkOutput("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sau_serdes.md
# sau_serdes

Parametrised full-duplex serial/parallel adapter, the successor to the fixed 8-bit serial adapter unit. It converts parallel words to a serial bit stream and assembles a serial bit stream back into parallel words, with configurable width and bit order. Both directions use valid/ready handshakes and a shared bit-rate strobe, and an internal loopback is available. It sits between the DES datapath (parallel words) and the serial link pins.

## Interface

Parameters:
- WIDTH, 8: word width in bits; must be ≥ 2.
- LSB_FIRST, 1: 1 = bit 0 is sent/received first; 0 = bit WIDTH-1 first.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- bit_en  in  1  bit-rate strobe; serial state advances only on cycles with bit_en=1.
- loopback  in  1  1 = receiver takes the internal sout/sout_sof instead of sin/sin_sof.
- clr_err  in  1  synchronous clear of the sticky error flags.
- tx_data  in  WIDTH  parallel word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  transmitter accepts a word this cycle (combinational).
- sout  out  1  serial data out.
- sout_sof  out  1  high while the first bit of a word is on sout.
- sout_act  out  1  high while a word is being shifted out.
- sin  in  1  serial data in, sampled on bit_en.
- sin_sof  in  1  marks the first bit of a received word, sampled on bit_en.
- rx_data  out  WIDTH  received word.
- rx_valid  out  1  rx_data valid; held until accepted.
- rx_ready  in  1  consumer accepts rx_data.
- rx_ovf  out  1  sticky overrun flag.
- rx_ferr  out  1  sticky framing-error flag.

## Operation

- Reset values: sout=1, sout_sof=0, sout_act=0, rx_data=0, rx_valid=0, rx_ovf=0, rx_ferr=0. Bit counters are 0 and the TX FSM is in IDLE.
- TX FSM states:
  - IDLE: sout=1, sout_act=0.
  - SHIFT: sout = current bit, sout_act=1.
- tx_ready = (state==IDLE) | (state==SHIFT & bit_en & tx_cnt==WIDTH-1).
- A handshake (tx_valid & tx_ready) loads the shift register, sets tx_cnt=0 and enters or stays in SHIFT.
- In SHIFT, each cycle with bit_en=1 consumes the current bit and increments tx_cnt.
- After the last bit is consumed, the FSM reloads if a handshake occurred that cycle, giving a gapless back-to-back word. Otherwise it returns to IDLE.
- sout_sof=1 exactly while tx_cnt==0 in SHIFT.
- Bit order:
  - LSB_FIRST=1: bit k of the word is sent as the k-th bit.
  - LSB_FIRST=0: bit WIDTH-1-k of the word is sent as the k-th bit.
- RX path: the bit source is sin/sin_sof, or sout/sout_sof when loopback=1. On each cycle with bit_en=1:
  - If sof=1: if rx_cnt≠0, set rx_ferr (partial word discarded). The bit is stored as the first bit and rx_cnt=1.
  - If sof=0: the bit is stored at position rx_cnt (mapped by LSB_FIRST) and rx_cnt increments. A bit arriving with rx_cnt==0 and sof=0 is still accepted, so the receiver is free-running aligned to WIDTH.
  - When the stored bit is the WIDTH-th, the word completes and rx_cnt returns to 0.
- Word completion:
  - If rx_valid=0, or rx_ready=1 in the same cycle: rx_data <= word and rx_valid <= 1.
  - Otherwise: the word is dropped, rx_data keeps the old value and rx_ovf is set.
- rx_valid clears on rx_valid & rx_ready unless a new word completes in the same cycle.
- clr_err=1 clears rx_ovf/rx_ferr. A set event in the same cycle wins.
- WIDTH=1 is unsupported. Counters are $clog2(WIDTH) bits, or 1 bit minimum.

## Timing

- TX latency: a handshake at cycle k puts the first bit on sout at k+1.
- Each bit stays on sout until the end of the next cycle with bit_en=1, including cycle k+1 itself.
- With bit_en held high, one bit per cycle and WIDTH cycles per word; back-to-back words have no idle bit.
- RX latency: rx_valid rises the cycle after the bit_en cycle that samples the last bit.
- Loopback, bit_en=1 continuous: handshake at k, rx_valid at k+WIDTH+1.
- bit_en=0 freezes both counters and the shift register; handshakes on the parallel sides still follow the rules above.
- rst asserted mid-word: all state and outputs go to reset values immediately. The partial word is lost, no rx_valid is produced, and no flag is set.

## Test plan

- WIDTH=8, LSB_FIRST=1, bit_en=1, tx_data=8'hA5 -> sout=1,0,1,0,0,1,0,1 over cycles k+1..k+8, sout_sof only at k+1, then sout=1 and sout_act=0.
- Back-to-back: 8'h3C then 8'hC3 with tx_valid held -> second handshake on the last bit of the first word; 16 consecutive data bits with no idle; sout_sof at k+1 and k+9.
- Loopback: loopback=1, rx_ready=1, send 8'h5A -> rx_data=8'h5A, rx_valid at k+9 for one cycle; with bit_en every 3rd cycle -> same data, 3x the spacing.
- Overrun: loopback with rx_ready=0, send 8'h11 then 8'h22 -> rx_data stays 8'h11 and rx_ovf=1; clr_err -> rx_ovf=0.
- Framing: sin_sof after 3 bits, then 8 bits of 8'hF0 -> rx_ferr=1, rx_data=8'hF0; WIDTH=12, LSB_FIRST=0, tx_data=12'h801 -> first bit 1, then ten 0s, last bit 1.
- Reset mid-word: rst after 4 bits of a received word -> rx_valid stays 0; next full word is received correctly with rx_ferr=0.
